// File: rtl/if_id_reg_pkg.sv
// -----------------------------------------------------------------------------
// if_id_reg_pkg
// Shared MIPS encoding constants and IF/ID register types.
//   OP_*        : 6-bit primary opcodes
//   FUNC_*      : 6-bit R-type funct codes
//   INST_TYPE_* : 4-bit instruction type codes used by display/trace logic
//   reg_action_e / select_action : per-cycle update choice of the IF/ID register
// These encodings are also used by the fetch and decode stages.
// -----------------------------------------------------------------------------
package if_id_reg_pkg;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (inst[5:0])
    localparam logic [5:0] FUNC_SLL = 6'b000000;
    localparam logic [5:0] FUNC_SRL = 6'b000010;
    localparam logic [5:0] FUNC_SRA = 6'b000011;
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_NOR = 6'b100111;
    localparam logic [5:0] FUNC_SLT = 6'b101010;

    // Instruction type codes reported on ID_ins_type
    localparam logic [3:0] INST_TYPE_NONE = 4'd0;
    localparam logic [3:0] INST_TYPE_ADD  = 4'd1;
    localparam logic [3:0] INST_TYPE_SUB  = 4'd2;
    localparam logic [3:0] INST_TYPE_AND  = 4'd3;
    localparam logic [3:0] INST_TYPE_OR   = 4'd4;
    localparam logic [3:0] INST_TYPE_NOR  = 4'd5;
    localparam logic [3:0] INST_TYPE_SLT  = 4'd6;
    localparam logic [3:0] INST_TYPE_SLL  = 4'd7;
    localparam logic [3:0] INST_TYPE_SRL  = 4'd8;
    localparam logic [3:0] INST_TYPE_SRA  = 4'd9;
    localparam logic [3:0] INST_TYPE_LW   = 4'd10;
    localparam logic [3:0] INST_TYPE_SW   = 4'd11;
    localparam logic [3:0] INST_TYPE_BEQ  = 4'd12;
    localparam logic [3:0] INST_TYPE_BNE  = 4'd13;
    localparam logic [3:0] INST_TYPE_JMP  = 4'd14;

    // What the IF/ID register does on a given edge
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_FLUSH = 2'd1,
        ACT_STALL = 2'd2
    } reg_action_e;

    // Stall wins over squash: a branch still sitting in ID behind a
    // load-use hazard has not resolved, so its squash request is not final.
    function automatic reg_action_e select_action(input logic stall,
                                                  input logic branch,
                                                  input logic jump);
        reg_action_e act;
        if (stall) begin
            act = ACT_STALL;
        end else if (branch || jump) begin
            act = ACT_FLUSH;
        end else begin
            act = ACT_LOAD;
        end
        return act;
    endfunction

endpackage

// File: rtl/if_id_reg_if.sv
// -----------------------------------------------------------------------------
// if_id_reg_if
// Bus between the fetch stage / hazard unit and the IF/ID register.
//   fetch_pc, if_pc4, if_inst : fetched instruction, its address and PC+1
//   id_wpcir                  : 1 = stall (hold register)
//   ctrl_branch, jmp_stall    : squash requests from ID
//   id_*                      : registered instruction presented to decode
//   ID_ins_type/number        : trace classification and PC tag
// modport master: fetch/hazard side; modport slave: the IF/ID register.
// -----------------------------------------------------------------------------
interface if_id_reg_if #(
    parameter int DATA_W = 32,
    parameter int NUM_W  = 4
);
    logic [DATA_W-1:0] fetch_pc;
    logic [DATA_W-1:0] if_pc4;
    logic [DATA_W-1:0] if_inst;
    logic              id_wpcir;
    logic              ctrl_branch;
    logic              jmp_stall;
    logic [DATA_W-1:0] id_inst;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_pc4;
    logic              id_valid;
    logic [3:0]        ID_ins_type;
    logic [NUM_W-1:0]  ID_ins_number;

    modport master (
        output fetch_pc, if_pc4, if_inst, id_wpcir, ctrl_branch, jmp_stall,
        input  id_inst, id_pc, id_pc4, id_valid, ID_ins_type, ID_ins_number
    );

    modport slave (
        input  fetch_pc, if_pc4, if_inst, id_wpcir, ctrl_branch, jmp_stall,
        output id_inst, id_pc, id_pc4, id_valid, ID_ins_type, ID_ins_number
    );
endinterface

// File: rtl/if_id_reg_inst_classify.sv
// -----------------------------------------------------------------------------
// inst_classify
// Combinational MIPS instruction classifier.
//   inst     in  DATA_W : instruction word (MIPS layout, DATA_W >= 32)
//   ins_type out 4      : INST_TYPE_* code; NONE for NOP and anything unknown
// -----------------------------------------------------------------------------
module inst_classify
    import if_id_reg_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] inst,
    output logic [3:0]        ins_type
);

    logic [5:0] opcode_s;
    logic [5:0] funct_s;
    logic       is_zero_s;
    logic       unused_fields_s;

    assign opcode_s  = inst[31:26];
    assign funct_s   = inst[5:0];
    assign is_zero_s = (inst == {DATA_W{1'b0}});
    // Register/immediate fields do not affect the type
    assign unused_fields_s = ^inst[25:6];

    // Decode opcode/funct into a type code; the all-zero NOP would otherwise decode as SLL
    always_comb begin
        ins_type = INST_TYPE_NONE;
        if (is_zero_s) begin
            ins_type = INST_TYPE_NONE;
        end else begin
            case (opcode_s)
                OP_RTYPE: begin
                    case (funct_s)
                        FUNC_ADD: ins_type = INST_TYPE_ADD;
                        FUNC_SUB: ins_type = INST_TYPE_SUB;
                        FUNC_AND: ins_type = INST_TYPE_AND;
                        FUNC_OR:  ins_type = INST_TYPE_OR;
                        FUNC_NOR: ins_type = INST_TYPE_NOR;
                        FUNC_SLT: ins_type = INST_TYPE_SLT;
                        FUNC_SLL: ins_type = INST_TYPE_SLL;
                        FUNC_SRL: ins_type = INST_TYPE_SRL;
                        FUNC_SRA: ins_type = INST_TYPE_SRA;
                        default:  ins_type = INST_TYPE_NONE;
                    endcase
                end
                OP_ADDI: ins_type = INST_TYPE_ADD;
                OP_ANDI: ins_type = INST_TYPE_AND;
                OP_ORI:  ins_type = INST_TYPE_OR;
                OP_LW:   ins_type = INST_TYPE_LW;
                OP_SW:   ins_type = INST_TYPE_SW;
                OP_BEQ:  ins_type = INST_TYPE_BEQ;
                OP_BNE:  ins_type = INST_TYPE_BNE;
                OP_J:    ins_type = INST_TYPE_JMP;
                default: ins_type = INST_TYPE_NONE;
            endcase
        end
    end

endmodule

// File: rtl/if_id_reg_sat_cnt.sv
// -----------------------------------------------------------------------------
// sat_cnt
// Saturating up-counter for debug statistics.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count this cycle
//   count    : registered value; sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Increment on request until the counter is full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register of the 5-stage MIPS pipeline.
//   clk, rst  : pipeline clock, asynchronous active-high reset
//   bus       : if_id_reg_if.slave - fetch inputs, stall/squash controls,
//               registered instruction, address, PC+1, valid, type and tag
//   stall_cnt : saturating count of stalled cycles
//   flush_cnt : saturating count of cycles where a squash was applied
// Each edge either holds (stall), inserts a bubble (squash) or loads the
// fetched instruction. A bubble keeps the fetch address so the trace shows
// where the squashed slot came from.
// -----------------------------------------------------------------------------
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    if_id_reg_if.slave       bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    reg_action_e       act_s;
    logic [3:0]        fetch_type_s;
    logic              stall_inc_s;
    logic              flush_inc_s;

    logic [DATA_W-1:0] inst_r;
    logic [DATA_W-1:0] pc_r;
    logic [DATA_W-1:0] pc4_r;
    logic              valid_r;
    logic [3:0]        type_r;
    logic [NUM_W-1:0]  num_r;

    // Classify the instruction currently being fetched
    inst_classify #(
        .DATA_W (DATA_W)
    ) u_classify (
        .inst     (bus.if_inst),
        .ins_type (fetch_type_s)
    );

    // Choose this edge's action; flush counts once even with both squash inputs set
    always_comb begin
        act_s = select_action(bus.id_wpcir, bus.ctrl_branch, bus.jmp_stall);
        if (act_s == ACT_STALL) begin
            stall_inc_s = 1'b1;
            flush_inc_s = 1'b0;
        end else if (act_s == ACT_FLUSH) begin
            stall_inc_s = 1'b0;
            flush_inc_s = 1'b1;
        end else begin
            stall_inc_s = 1'b0;
            flush_inc_s = 1'b0;
        end
    end

    // IF/ID pipeline state: hold, bubble or load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_r  <= {DATA_W{1'b0}};
            pc_r    <= {DATA_W{1'b0}};
            pc4_r   <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
            type_r  <= INST_TYPE_NONE;
            num_r   <= {NUM_W{1'b0}};
        end else begin
            case (act_s)
                ACT_STALL: begin
                    inst_r  <= inst_r;
                    pc_r    <= pc_r;
                    pc4_r   <= pc4_r;
                    valid_r <= valid_r;
                    type_r  <= type_r;
                    num_r   <= num_r;
                end
                ACT_FLUSH: begin
                    inst_r  <= {DATA_W{1'b0}};
                    pc_r    <= bus.fetch_pc;
                    pc4_r   <= bus.if_pc4;
                    valid_r <= 1'b0;
                    type_r  <= INST_TYPE_NONE;
                    num_r   <= bus.fetch_pc[NUM_W-1:0];
                end
                ACT_LOAD: begin
                    inst_r  <= bus.if_inst;
                    pc_r    <= bus.fetch_pc;
                    pc4_r   <= bus.if_pc4;
                    valid_r <= 1'b1;
                    type_r  <= fetch_type_s;
                    num_r   <= bus.fetch_pc[NUM_W-1:0];
                end
                default: begin
                    inst_r  <= inst_r;
                    pc_r    <= pc_r;
                    pc4_r   <= pc4_r;
                    valid_r <= valid_r;
                    type_r  <= type_r;
                    num_r   <= num_r;
                end
            endcase
        end
    end

    sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    sat_cnt #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );

    assign bus.id_inst       = inst_r;
    assign bus.id_pc         = pc_r;
    assign bus.id_pc4        = pc4_r;
    assign bus.id_valid      = valid_r;
    assign bus.ID_ins_type   = type_r;
    assign bus.ID_ins_number = num_r;

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline register between the instruction-fetch stage and the decode stage of the 5-stage MIPS pipeline.
- Captures the fetched instruction, its word address and PC+1 every cycle.
- Holds its contents on a load-use stall and inserts a bubble on a taken branch or jump.
- Classifies each captured instruction into a 4-bit type code for the display/trace logic, and keeps saturating stall and flush counters for the debug panel.

Parameters:
- DATA_W, 32, width of instruction and PC words
- NUM_W, 4, width of the instruction-number tag (low PC bits)
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- fetch_pc  in  DATA_W  word address of the instruction presented on if_inst
- if_pc4  in  DATA_W  fetch_pc+1 (word-addressed)
- if_inst  in  DATA_W  instruction word from instruction memory
- id_wpcir  in  1  1 = stall: hold register contents
- ctrl_branch  in  1  1 = taken branch resolved in ID: squash fetched instruction
- jmp_stall  in  1  1 = jump in ID: squash fetched instruction
- id_inst  out  DATA_W  registered instruction
- id_pc  out  DATA_W  registered instruction address
- id_pc4  out  DATA_W  registered PC+1
- id_valid  out  1  1 = id_inst is a real instruction; 0 = bubble
- ID_ins_type  out  4  type code of id_inst
- ID_ins_number  out  NUM_W  fetch_pc[NUM_W-1:0] of id_inst
- stall_cnt  out  CNT_W  cycles with id_wpcir=1
- flush_cnt  out  CNT_W  cycles in which a squash was applied

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-stall) forces:
  - id_inst=0, id_pc=0, id_pc4=0, id_valid=0
  - ID_ins_type=NONE (4'h0), ID_ins_number=0
  - stall_cnt=0, flush_cnt=0
- Reset release takes effect on the next posedge.
- Latency: one cycle from if_inst to id_inst.
- Per-posedge priority, evaluated in this order:
  - Stall (id_wpcir=1): every data output is held unchanged. stall_cnt += 1. ctrl_branch and jmp_stall are ignored because the branch in ID is not yet final. flush_cnt is unchanged.
  - Flush (id_wpcir=0 and (ctrl_branch or jmp_stall)):
    - id_inst<=0, id_valid<=0, ID_ins_type<=NONE
    - id_pc<=fetch_pc, id_pc4<=if_pc4, ID_ins_number<=fetch_pc[3:0]
    - flush_cnt += 1 (one count even if both squash inputs are high)
  - Load (otherwise):
    - id_inst<=if_inst, id_pc<=fetch_pc, id_pc4<=if_pc4
    - id_valid<=1, ID_ins_number<=fetch_pc[3:0]
    - ID_ins_type<=classify(if_inst)
- Counters saturate at all-ones and never wrap.
- Classification (combinational, applied at load):
  - if_inst==0 -> NONE (a NOP is not reported as SLL)
  - opcode 000000, funct:
    - 100000 ADD=1, 100010 SUB=2, 100100 AND=3, 100101 OR=4, 100111 NOR=5
    - 101010 SLT=6, 000000 SLL=7, 000010 SRL=8, 000011 SRA=9
    - any other funct -> NONE
  - opcodes:
    - 001000 ADDI -> ADD, 001100 ANDI -> AND, 001101 ORI -> OR
    - 100011 LW=10, 101011 SW=11, 000100 BEQ=12, 000101 BNE=13, 000010 J=14
  - anything else -> NONE
- No X propagation: every output is defined in every cycle after reset.

Decomposition:
- Shared package/include:
  - OP_* opcode and FUNC_* funct constants
  - INST_TYPE_* 4-bit codes (NONE=0 … JMP=14)
  - these are shared with the fetch and decode stages
- One sub-module: inst_classify.
  - Purely combinational: DATA_W instruction in, 4-bit type out.
  - Instantiated once here; reusable by the trace logic.
- Counter: a small saturating-increment sub-block, instantiated twice (stall_cnt, flush_cnt).

Test Plan:
- Reset: assert rst mid-cycle with registers loaded -> all outputs 0 immediately (before the next edge); ID_ins_type=0.
- Load: fetch_pc=5, if_inst=0x012A4020 (add), stall and squash low -> after 1 edge: id_inst=0x012A4020, id_pc=5, id_pc4=6, id_valid=1, ID_ins_type=1, ID_ins_number=5.
- Stall:
  - load lw 0x8C220004, then hold id_wpcir=1 for 3 edges while if_inst changes -> outputs hold lw/type 10 and stall_cnt=3.
  - release -> next instruction loads.
- Flush: ctrl_branch=1 and jmp_stall=1 together for 1 edge -> id_inst=0, id_valid=0, type 0, flush_cnt=1.
- Stall beats flush: id_wpcir=1 and ctrl_branch=1 -> contents held, flush_cnt unchanged, stall_cnt +1.
- Classification sweep:
  - each opcode/funct pair -> codes 1..14
  - inst 0x00000000 -> 0
  - funct 0x08 -> 0
  - ANDI 0x30420001 -> 3
- Saturation: preload-free run of 65540 stall cycles -> stall_cnt=0xFFFF.
